// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: rebuilds MSB-first WIDTH-bit words framed by sof,
// with a valid/ready holding register and overrun/sync error reporting.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module sipo_deframer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  output logic             perr,
  output logic             overrun,
  output logic             sync_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] pdata_q;
  logic             pvalid_q;
  logic             perr_q;
  logic             overrun_q;
  logic             sync_err_q;
  logic             busy_q;

  logic [WIDTH-1:0] shifted_d;
  logic [WIDTH-1:0] word_d;
  logic             perr_d;
  logic             last_bit_d;
  logic             complete_d;

  always_comb begin
    shifted_d  = {shreg_q[WIDTH-2:0], sin};
    last_bit_d = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SIPO_PARITY_EN
    // The full data word already sits in shreg; delivery waits for the parity bit.
    complete_d = (state_q == PAR) && sin_en && !sof;
    word_d     = shreg_q;
    perr_d     = (^shreg_q) ^ sin;
`else
    complete_d = (state_q == SHIFT) && sin_en && !sof && last_bit_d;
    word_d     = shifted_d;
    perr_d     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      pdata_q    <= '0;
      pvalid_q   <= 1'b0;
      perr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;

      if (sin_en) begin
        case (state_q)
          IDLE: begin
            if (sof) begin
              shreg_q <= {{(WIDTH-1){1'b0}}, sin};
              cnt_q   <= CNT_W'(1);
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
          SHIFT: begin
            if (sof) begin
              shreg_q    <= {{(WIDTH-1){1'b0}}, sin};
              cnt_q      <= CNT_W'(1);
              sync_err_q <= 1'b1;
            end else if (last_bit_d) begin
              shreg_q <= shifted_d;
              cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
              state_q <= PAR;
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              shreg_q <= shifted_d;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            if (sof) begin
              shreg_q    <= {{(WIDTH-1){1'b0}}, sin};
              cnt_q      <= CNT_W'(1);
              sync_err_q <= 1'b1;
              state_q    <= SHIFT;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
`endif
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end

      // Holding register: a completion while a word is held and not taken is dropped.
      if (complete_d) begin
        if (pvalid_q && !out_ready) begin
          overrun_q <= 1'b1;
        end else begin
          pdata_q  <= word_d;
          perr_q   <= perr_d;
          pvalid_q <= 1'b1;
          if (clr_ovr) overrun_q <= 1'b0;
        end
      end else begin
        if (pvalid_q && out_ready) pvalid_q <= 1'b0;
        if (clr_ovr) overrun_q <= 1'b0;
      end
    end
  end

  assign pdata    = pdata_q;
  assign pvalid   = pvalid_q;
  assign perr     = perr_q;
  assign overrun  = overrun_q;
  assign sync_err = sync_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (WIDTH=4); parity cases are
// built only when SIPO_PARITY_EN is defined.
module tb_sipo_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic       sof;
  logic       out_ready;
  logic       clr_ovr;
  logic [3:0] pdata;
  logic       pvalid;
  logic       perr;
  logic       overrun;
  logic       sync_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  sipo_deframer #(.WIDTH(4), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .sof       (sof),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .pdata     (pdata),
    .pvalid    (pvalid),
    .perr      (perr),
    .overrun   (overrun),
    .sync_err  (sync_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    sin    = b;
    sof    = s;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
    sof    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    send_bit(w[3], 1'b1);
    send_bit(w[2], 1'b0);
    send_bit(w[1], 1'b0);
    send_bit(w[0], 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  initial begin
    rst = 1'b0; sin = 1'b0; sin_en = 1'b0; sof = 1'b0;
    out_ready = 1'b1; clr_ovr = 1'b0;
    tick(); tick();
    chk("rst_pvalid", pvalid, 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_perr", perr, 0);
    rst = 1'b1;
    tick();

    // Basic word with an idle gap mid-word
    send_bit(1'b1, 1'b1);
    chk("t1_busy_first", busy, 1);
    tick();
    chk("t1_busy_gap", busy, 1);
    chk("t1_pvalid_early", pvalid, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    chk("t1_busy_par", busy, 1);
    send_bit(1'b1, 1'b0);
`endif
    chk("t1_pdata", pdata, 4'b1011);
    chk("t1_pvalid", pvalid, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_perr", perr, 0);
    tick();
    chk("t1_pvalid_gone", pvalid, 0);

    // Back-to-back words: sof on the edge right after completion
    send_word(4'b1110);
    chk("bb_first", pdata, 4'b1110);
    send_word(4'b0110);
    chk("bb_second", pdata, 4'b0110);
    chk("bb_pvalid", pvalid, 1);
    tick();
    chk("bb_consumed", pvalid, 0);

    // Overrun handling
    out_ready = 1'b0;
    send_word(4'b1100);
    chk("t2_pdata", pdata, 4'b1100);
    chk("t2_pvalid", pvalid, 1);
    send_word(4'b0011);
    chk("t2_overrun", overrun, 1);
    chk("t2_pdata_held", pdata, 4'b1100);
    clr_ovr = 1'b1;
    send_word(4'b1111);
    clr_ovr = 1'b0;
    chk("t2_set_wins", overrun, 1);
    chk("t2_pdata_held2", pdata, 4'b1100);
    out_ready = 1'b1;
    tick();
    chk("t2_consumed", pvalid, 0);
    chk("t2_overrun_sticky", overrun, 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t2_overrun_clr", overrun, 0);

    // Resync: sof mid-word
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("t3_no_err_yet", sync_err, 0);
    send_bit(1'b0, 1'b1);
    chk("t3_sync_err", sync_err, 1);
    chk("t3_busy", busy, 1);
    send_bit(1'b1, 1'b0);
    chk("t3_sync_err_pulse", sync_err, 0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("t3_pdata", pdata, 4'b0110);
    chk("t3_pvalid", pvalid, 1);
    tick();

    // Reset mid-word with a held output
    out_ready = 1'b0;
    send_word(4'b1111);
    chk("t4_held", pvalid, 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("t4_rst_pvalid", pvalid, 0);
    chk("t4_rst_pdata", pdata, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_overrun", overrun, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    send_word(4'b1001);
    chk("t4_pdata", pdata, 4'b1001);
    chk("t4_pvalid", pvalid, 1);
    tick();

    // Completion coinciding with consume of a held word
    out_ready = 1'b0;
    send_word(4'b1010);
    chk("t5_held", pdata, 4'b1010);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b1, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
`else
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0);
`endif
    chk("t5_pdata", pdata, 4'b0101);
    chk("t5_pvalid", pvalid, 1);
    chk("t5_overrun", overrun, 0);
    tick();
    chk("t5_consumed", pvalid, 0);

`ifdef SIPO_PARITY_EN
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("p_good_pdata", pdata, 4'b1011);
    chk("p_good_perr", perr, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("p_bad_pdata", pdata, 4'b1011);
    chk("p_bad_perr", perr, 1);
    // sof during the parity slot aborts and restarts
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("p_sync_err", sync_err, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("p_restart_pdata", pdata, 4'b0011);
    chk("p_restart_perr", perr, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
